// File: rtl/limbus_sysid_checker.sv
`timescale 1ns/1ps
// limbus_sysid_checker
//   Purpose : Avalon-MM read master that fetches word 0 (system ID) and word 1
//             (build timestamp) from the sysid slave, compares both against the
//             expected build constants and publishes match flags plus the raw
//             captured words. Boot logic gates limbus_sys bring-up on the flags.
//   Latency : one IDLE->RD_ID cycle, then per word (stall cycles + 1 + RD_LATENCY),
//             then one DONE cycle carrying the done pulse and the fresh flags.
//   Backpressure: av_read is held with a stable av_address for as long as the
//             slave asserts av_waitrequest; only one read is ever outstanding.
//
// Ports:
//   clock, reset_n  : rising-edge clock, synchronous active-low reset
//   start           : single-cycle request; ignored while busy (not queued)
//   av_address      : word address (0 = system ID, 1 = timestamp)
//   av_read         : read strobe, high only in the two read-issue states
//   av_waitrequest  : slave stall
//   av_readdata     : slave read data, valid RD_LATENCY cycles after accept
//   busy            : high from start accept through the DONE cycle
//   done            : one-cycle pulse when the results update
//   id_ok, ts_ok    : full 32-bit equality of the captured words
//   id_val, ts_val  : captured words, held until the next accepted start
//   timeout         : a read stalled for TIMEOUT_CYCLES (0 unless enabled)
//
// Build option: define SYSID_CHK_TIMEOUT_EN to add the per-read stall watchdog.
// Without it there is no counter logic, timeout is tied low and a stalled read
// waits indefinitely.

module limbus_sysid_checker #(
  parameter logic [31:0] EXP_ID         = 32'd666,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'd1354828801,
  parameter int unsigned RD_LATENCY     = 0,     // legal range 0..7
  parameter bit          AUTO_START     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_val,
  output logic [31:0] ts_val,
  output logic        timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Value loaded into the latency counter on the accept cycle; the capture
  // happens on the cycle the counter reads 0, i.e. RD_LATENCY cycles later.
  localparam logic [2:0] LAT_LOAD = (RD_LATENCY == 0) ? 3'd0 : 3'(RD_LATENCY - 1);

  state_t      state;
  state_t      next_state;
  logic        pending;      // auto-start request armed by reset
  logic [2:0]  lat_cnt;

  logic        launch;       // start accepted in IDLE
  logic        lat_load;     // read accepted with non-zero latency
  logic        cap_id;       // av_readdata holds word 0 this cycle
  logic        cap_ts;       // av_readdata holds word 1 this cycle
  logic        stall_expired;

  // ---------------------------------------------------------------------------
  // Next-state and Avalon outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    lat_load   = 1'b0;
    cap_id     = 1'b0;
    cap_ts     = 1'b0;
    av_read    = 1'b0;
    av_address = 1'b0;
    busy       = (state != IDLE);
    done       = (state == DONE);

    case (state)
      IDLE: begin
        if (start || pending) begin
          next_state = RD_ID;
          launch     = 1'b1;
        end
      end

      RD_ID: begin
        av_read = 1'b1;
        if (!av_waitrequest) begin
          if (RD_LATENCY == 0) begin
            cap_id     = 1'b1;
            next_state = RD_TS;
          end else begin
            lat_load   = 1'b1;
            next_state = LAT_ID;
          end
        end else if (stall_expired) begin
          next_state = DONE;
        end
      end

      LAT_ID: begin
        if (lat_cnt == 3'd0) begin
          cap_id     = 1'b1;
          next_state = RD_TS;
        end
      end

      RD_TS: begin
        av_read    = 1'b1;
        av_address = 1'b1;
        if (!av_waitrequest) begin
          if (RD_LATENCY == 0) begin
            cap_ts     = 1'b1;
            next_state = DONE;
          end else begin
            lat_load   = 1'b1;
            next_state = LAT_TS;
          end
        end else if (stall_expired) begin
          next_state = DONE;
        end
      end

      LAT_TS: begin
        // Address stays on word 1 until the state machine leaves this read.
        av_address = 1'b1;
        if (lat_cnt == 3'd0) begin
          cap_ts     = 1'b1;
          next_state = DONE;
        end
      end

      DONE: begin
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and result datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= AUTO_START;
      lat_cnt <= 3'd0;
      id_val  <= 32'd0;
      ts_val  <= 32'd0;
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
    end else begin
      state <= next_state;

      if (launch) begin
        pending <= 1'b0;
        id_val  <= 32'd0;
        ts_val  <= 32'd0;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
      end

      if (lat_load) begin
        lat_cnt <= LAT_LOAD;
      end else if (lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end

      if (cap_id) begin
        id_val <= av_readdata;
      end

      // Flags are registered on the edge into DONE; the timestamp compare uses
      // the word being captured on that same edge.
      if (cap_ts) begin
        ts_val <= av_readdata;
        id_ok  <= (id_val == EXP_ID);
        ts_ok  <= (av_readdata == EXP_TIMESTAMP);
      end

      if (stall_expired) begin
        id_ok <= 1'b0;
        ts_ok <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional stall watchdog
  // ---------------------------------------------------------------------------
`ifdef SYSID_CHK_TIMEOUT_EN
  localparam logic [31:0] STALL_LIMIT =
      (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  logic        in_rd;
  logic [31:0] stall_cnt;

  assign in_rd = (state == RD_ID) || (state == RD_TS);

  // stall_cnt counts the stall cycles already spent in the current read, so the
  // watchdog fires on the TIMEOUT_CYCLES-th consecutive stall cycle.
  assign stall_expired = in_rd && av_waitrequest && (stall_cnt == STALL_LIMIT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
      timeout   <= 1'b0;
    end else begin
      if (next_state != state) begin
        stall_cnt <= 32'd0;
      end else if (in_rd && av_waitrequest) begin
        stall_cnt <= stall_cnt + 32'd1;
      end

      if (launch) begin
        timeout <= 1'b0;
      end else if (stall_expired) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign stall_expired      = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_limbus_sysid_checker.sv
`timescale 1ns/1ps
// Bench for limbus_sysid_checker: two instances (RD_LATENCY 0 and 2) each with
// a behavioural Avalon slave whose stall length per address and returned words
// are set by the test. Expected results come from a cycle-count formula and the
// equality rules, not from the RTL state machine.
module tb_limbus_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd666;
  localparam logic [31:0] EXP_TS = 32'd1354828801;
  localparam int          TMO    = 8;
  localparam int          STUCK  = 100000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n;
  logic [1:0]  start;
  logic [1:0]  rd;
  logic [1:0]  addr;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  id_ok;
  logic [1:0]  ts_ok;
  logic [1:0]  tmo;
  logic [31:0] idv [2];
  logic [31:0] tsv [2];

  logic [31:0] mem    [2][2];
  int          wait_n [2][2];

  int n_cmp = 0;
  int n_bad = 0;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      localparam int L  = (g == 0) ? 0 : 2;
      localparam int LI = (L == 0) ? 0 : L - 1;
      int          stall = 0;
      bit          sr_v [8];
      bit          sr_a [8];
      logic        wreq;
      logic [31:0] rdat;

      assign wreq = rd[g] && (stall < wait_n[g][addr[g]]);

      always @(posedge clk) begin
        if (rd[g] && wreq) stall <= stall + 1;
        else               stall <= 0;
        sr_v[0] <= rd[g] && !wreq;
        sr_a[0] <= addr[g];
        for (int k = 1; k < 8; k++) begin
          sr_v[k] <= sr_v[k-1];
          sr_a[k] <= sr_a[k-1];
        end
      end

      always_comb begin
        rdat = 32'hBAD0_BAD0;
        if (L == 0) begin
          if (rd[g] && !wreq) rdat = mem[g][addr[g]];
        end else if (sr_v[LI]) begin
          rdat = mem[g][sr_a[LI]];
        end
      end

      limbus_sysid_checker #(
        .RD_LATENCY    (L),
        .TIMEOUT_CYCLES(TMO)
      ) u_dut (
        .clock         (clk),
        .reset_n       (rst_n[g]),
        .start         (start[g]),
        .av_address    (addr[g]),
        .av_read       (rd[g]),
        .av_waitrequest(wreq),
        .av_readdata   (rdat),
        .busy          (busy[g]),
        .done          (done[g]),
        .id_ok         (id_ok[g]),
        .ts_ok         (ts_ok[g]),
        .id_val        (idv[g]),
        .ts_val        (tsv[g]),
        .timeout       (tmo[g])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int d, input logic [31:0] m0, input logic [31:0] m1,
                       input int w0, input int w1);
    mem[d][0]    = m0;
    mem[d][1]    = m1;
    wait_n[d][0] = w0;
    wait_n[d][1] = w1;
  endtask

  // Called on the first cycle the DUT sits in its first read state.
  task automatic measure(input int d, input logic [31:0] m0, input logic [31:0] m1,
                         input int w0, input int w1, input logic eid, input logic ets);
    int n;
    int rc0;
    int rc1;
    int L;
    L = (d == 0) ? 0 : 2;
    n = 0; rc0 = 0; rc1 = 0;
    while (n < 500) begin
      if (rd[d]) begin
        if (addr[d]) rc1++;
        else         rc0++;
      end
      if (done[d]) break;
      cyc();
      n++;
    end
    chk("done_cycle",   32'(n),   32'(w0 + w1 + 2 + 2 * L));
    chk("rd_cyc_addr0", 32'(rc0), 32'(w0 + 1));
    chk("rd_cyc_addr1", 32'(rc1), 32'(w1 + 1));
    chk("busy_in_done", 32'(busy[d]),  32'd1);
    chk("id_ok",        32'(id_ok[d]), 32'(eid));
    chk("ts_ok",        32'(ts_ok[d]), 32'(ets));
    chk("id_val",       idv[d], m0);
    chk("ts_val",       tsv[d], m1);
    chk("timeout_low",  32'(tmo[d]),   32'd0);
    cyc();
    chk("busy_after",   32'(busy[d]),  32'd0);
    chk("done_pulse",   32'(done[d]),  32'd0);
    chk("id_val_hold",  idv[d], m0);
    chk("id_ok_hold",   32'(id_ok[d]), 32'(eid));
  endtask

  task automatic run_check(input int d, input logic [31:0] m0, input logic [31:0] m1,
                           input int w0, input int w1, input logic eid, input logic ets);
    setup(d, m0, m1, w0, w1);
    start[d] = 1'b1;
    cyc();
    start[d] = 1'b0;
    measure(d, m0, m1, w0, w1, eid, ets);
  endtask

  task automatic check_zero(input int d);
    chk("rst_read",   32'(rd[d]),    32'd0);
    chk("rst_addr",   32'(addr[d]),  32'd0);
    chk("rst_busy",   32'(busy[d]),  32'd0);
    chk("rst_done",   32'(done[d]),  32'd0);
    chk("rst_id_ok",  32'(id_ok[d]), 32'd0);
    chk("rst_ts_ok",  32'(ts_ok[d]), 32'd0);
    chk("rst_id_val", idv[d], 32'd0);
    chk("rst_ts_val", tsv[d], 32'd0);
    chk("rst_tmo",    32'(tmo[d]),   32'd0);
  endtask

  // One reset cycle, then the auto-start check runs with a good slave.
  task automatic reset_recover(input int d);
    setup(d, EXP_ID, EXP_TS, 0, 0);
    rst_n[d] = 1'b0;
    cyc();
    check_zero(d);
    rst_n[d] = 1'b1;
    cyc();
    measure(d, EXP_ID, EXP_TS, 0, 0, 1'b1, 1'b1);
  endtask

  typedef struct {
    int          d;
    logic [31:0] m0;
    logic [31:0] m1;
    int          w0;
    int          w1;
    logic        eid;
    logic        ets;
  } vec_t;

  vec_t tv [6];

  initial begin
    int n;
    int nd;
    int nb;
    int d;
    logic [31:0] m0;
    logic [31:0] m1;
    int w0;
    int w1;

    tv[0] = '{0, EXP_ID,        EXP_TS,        0, 0, 1'b1, 1'b1};
    tv[1] = '{0, 32'd667,       EXP_TS,        0, 0, 1'b0, 1'b1};
    tv[2] = '{1, EXP_ID,        EXP_TS,        5, 0, 1'b1, 1'b1};
    tv[3] = '{1, EXP_ID,        32'd0,         1, 2, 1'b1, 1'b0};
    tv[4] = '{0, 32'd0,         EXP_TS - 1,    0, 3, 1'b0, 1'b0};
    tv[5] = '{1, 32'h8000_029A, EXP_TS,        2, 2, 1'b0, 1'b1};

    rst_n = 2'b00;
    start = 2'b00;
    setup(0, EXP_ID, EXP_TS, 0, 0);
    setup(1, EXP_ID, EXP_TS, 0, 0);
    cyc();
    cyc();
    check_zero(0);
    check_zero(1);

    // Auto-start after reset, zero-wait slave, both latencies.
    rst_n[0] = 1'b1;
    cyc();
    measure(0, EXP_ID, EXP_TS, 0, 0, 1'b1, 1'b1);
    rst_n[1] = 1'b1;
    cyc();
    measure(1, EXP_ID, EXP_TS, 0, 0, 1'b1, 1'b1);

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      run_check(tv[i].d, tv[i].m0, tv[i].m1, tv[i].w0, tv[i].w1, tv[i].eid, tv[i].ets);
    end

    // Reset while results are non-zero clears everything, then auto-start.
    reset_recover(1);

    // start during RD_TS and during DONE is ignored.
    setup(0, EXP_ID, EXP_TS, 0, 0);
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    cyc();
    start[0] = 1'b1;
    cyc();
    chk("ign_done_seen", 32'(done[0]), 32'd1);
    cyc();
    start[0] = 1'b0;
    nd = 0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (done[0]) nd++;
      if (busy[0]) nb++;
      cyc();
    end
    chk("ign_extra_done", 32'(nd), 32'd0);
    chk("ign_busy_cycles", 32'(nb), 32'd0);

    // Reset for one cycle during LAT_ID, then a fresh auto-started check.
    setup(1, EXP_ID, EXP_TS, 0, 0);
    start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    cyc();
    chk("lat_read_low", 32'(rd[1]),   32'd0);
    chk("lat_busy",     32'(busy[1]), 32'd1);
    reset_recover(1);

    // Waitrequest stuck high on address 0.
    setup(0, EXP_ID, EXP_TS, STUCK, 0);
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
`ifdef SYSID_CHK_TIMEOUT_EN
    n = 0;
    while (rd[0] && n < 100) begin
      cyc();
      n++;
    end
    chk("tmo_stall_cycles", 32'(n),        32'(TMO));
    chk("tmo_done",         32'(done[0]),  32'd1);
    chk("tmo_flag",         32'(tmo[0]),   32'd1);
    chk("tmo_id_ok",        32'(id_ok[0]), 32'd0);
    chk("tmo_ts_ok",        32'(ts_ok[0]), 32'd0);
    cyc();
    chk("tmo_busy_after",   32'(busy[0]),  32'd0);
    chk("tmo_flag_hold",    32'(tmo[0]),   32'd1);
    // Stuck on the timestamp read: the captured ID is retained.
    setup(0, EXP_ID, EXP_TS, 0, STUCK);
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 100) begin
      cyc();
      n++;
    end
    chk("tmo2_cycles",  32'(n),        32'(TMO + 1));
    chk("tmo2_flag",    32'(tmo[0]),   32'd1);
    chk("tmo2_id_val",  idv[0],        EXP_ID);
    chk("tmo2_id_ok",   32'(id_ok[0]), 32'd0);
    chk("tmo2_read",    32'(rd[0]),    32'd0);
    cyc();
    run_check(0, EXP_ID, EXP_TS, 0, 0, 1'b1, 1'b1);
`else
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      if (done[0]) nd++;
      cyc();
    end
    chk("stuck_busy", 32'(busy[0]), 32'd1);
    chk("stuck_read", 32'(rd[0]),   32'd1);
    chk("stuck_addr", 32'(addr[0]), 32'd0);
    chk("stuck_tmo",  32'(tmo[0]),  32'd0);
    chk("stuck_done", 32'(nd),      32'd0);
    reset_recover(0);
`endif

    // Randomized checks against the equality/timing model.
    for (int i = 0; i < 40; i++) begin
      d  = int'($urandom_range(0, 1));
      m0 = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      m1 = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      w0 = int'($urandom_range(0, 6));
      w1 = int'($urandom_range(0, 6));
      repeat ($urandom_range(0, 3)) cyc();
      run_check(d, m0, m1, w0, w1, (m0 == EXP_ID), (m1 == EXP_TS));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/limbus_sysid_checker.md
Name: limbus_sysid_checker

Overview:
- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its readdata.
- Reads word 0 (system ID) and word 1 (build timestamp), compares each against expected values, and publishes match flags plus captured values.
- Software and boot logic use these flags to gate bring-up of limbus_sys.
- Runs once automatically after reset, and again on each software start pulse.

Parameters:
- EXP_ID, 32'd666, expected value at address 0.
- EXP_TIMESTAMP, 32'd1354828801, expected value at address 1.
- RD_LATENCY, 0, cycles from read accept (read=1, waitrequest=0) to valid readdata; legal range 0..7.
- AUTO_START, 1, when 1 a check starts on the first cycle after reset_n deasserts.
- TIMEOUT_CYCLES, 255, maximum waitrequest stall per read; used only with SYSID_CHK_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to run a check.
- av_address  out  1  word address driven to the sysid slave.
- av_read  out  1  read strobe.
- av_waitrequest  in  1  slave stall; tie to 0 for a zero-wait slave.
- av_readdata  in  32  slave read data.
- busy  out  1  high from start accept through the DONE state.
- done  out  1  one-cycle pulse when results update.
- id_ok  out  1  captured ID equals EXP_ID.
- ts_ok  out  1  captured timestamp equals EXP_TIMESTAMP.
- id_val  out  32  captured word 0.
- ts_val  out  32  captured word 1.
- timeout  out  1  a read stalled past TIMEOUT_CYCLES; constant 0 without the macro.

Behaviour:
- Reset (reset_n=0 at a clock edge) forces all outputs to 0 and the state to IDLE.
  - If AUTO_START=1, an internal pending-start flag is set; it is consumed on the first post-reset IDLE cycle.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.
- IDLE
  - start=1 (or pending-start) -> RD_ID.
  - On entry to RD_ID: clear id_ok, ts_ok, id_val, ts_val and timeout; set busy=1.
- RD_ID
  - av_read=1, av_address=0.
  - av_read stays high while av_waitrequest=1.
  - Accept cycle (av_waitrequest=0): if RD_LATENCY=0, capture av_readdata into id_val and go to RD_TS; otherwise go to LAT_ID with the latency counter loaded to RD_LATENCY-1.
- LAT_ID
  - av_read=0.
  - Counter decrements each cycle.
  - On the cycle the counter is 0, capture av_readdata into id_val and go to RD_TS.
- RD_TS / LAT_TS
  - Same as RD_ID / LAT_ID with av_address=1; capture into ts_val.
  - After capture, go to DONE.
- DONE (one cycle)
  - done=1.
  - id_ok = (id_val==EXP_ID), ts_ok = (ts_val==EXP_TIMESTAMP), both registered on entry to DONE.
  - busy drops on the next cycle; return to IDLE.
- av_address is held stable for the whole stall; it changes only on state transitions. av_read is never high outside RD_ID and RD_TS.
- Read throughput: at most one outstanding read; the next read is never issued before the previous capture.
- start while busy=1, including during the DONE cycle: ignored, not queued.
- Results (id_val, ts_val, id_ok, ts_ok) hold until the next accepted start.
- Reset mid-operation:
  - av_read deasserts at that edge.
  - Partial captures are discarded.
  - Any read data returning after reset is ignored.
- Comparison is a full 32-bit equality; no masking.

Optional Feature:
- Macro SYSID_CHK_TIMEOUT_EN.
- Defined:
  - A stall counter runs in RD_ID/RD_TS while av_waitrequest=1 and resets on each state entry.
  - When it reaches TIMEOUT_CYCLES: deassert av_read, set timeout=1, force id_ok=0 and ts_ok=0, and go to DONE (done pulses).
  - Values captured before the timeout are retained.
- Undefined:
  - No counter logic; timeout is tied to 0.
  - Stalls wait indefinitely.

Test Plan:
- Zero-wait slave returning 666 / 1354828801, RD_LATENCY=0, AUTO_START=1 -> after reset, av_read is high for 2 cycles (address 0 then 1); done pulses on cycle 3; id_ok=1, ts_ok=1, id_val=666, ts_val=1354828801.
- Slave returns 667 at address 0 -> id_ok=0, ts_ok=1, id_val=667.
- av_waitrequest held high 5 cycles on address 0, RD_LATENCY=2 -> av_read high for 6 cycles with av_address=0 stable; capture occurs 2 cycles after accept; final flags correct.
- start pulsed in RD_TS and again in the DONE cycle -> no second check; exactly one done pulse.
- reset_n=0 for one cycle during LAT_ID -> next cycle av_read=0, all outputs 0; with AUTO_START=1 a fresh check completes normally.
- SYSID_CHK_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, waitrequest stuck high -> after 8 stall cycles av_read=0, done pulses, timeout=1, id_ok=0, ts_ok=0; without the macro, busy stays high and timeout=0.
